// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared constants, state encoding and distance helper for laser_host
package laser_pkg;
  localparam int PT_NUM    = 40;
  localparam int COORD_W   = 4;
  localparam int RADIUS_SQ = 16;
  localparam int COVER_W   = 6;
  localparam int D2_W      = 9;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_SCORE, S_REPORT} state_t;

  // Squared Euclidean distance; 9 bits holds the worst case 15^2 + 15^2 = 450.
  function automatic logic [D2_W-1:0] dist_sq(input logic [COORD_W-1:0] ax, ay, bx, by);
    logic [COORD_W-1:0] dx, dy;
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
    return D2_W'(dx) * D2_W'(dx) + D2_W'(dy) * D2_W'(dy);
  endfunction
endpackage

// File: rtl/laser_cover_chk.sv
// rtl/laser_cover_chk.sv - combinational check: is a point within radius 4 of either centre
module laser_cover_chk
  import laser_pkg::*;
(
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] c1x,
  input  logic [COORD_W-1:0] c1y,
  input  logic [COORD_W-1:0] c2x,
  input  logic [COORD_W-1:0] c2y,
  output logic               covered
);
  assign covered = (dist_sq(px, py, c1x, c1y) <= D2_W'(RADIUS_SQ)) ||
                   (dist_sq(px, py, c2x, c2y) <= D2_W'(RADIUS_SQ));
endmodule

// File: rtl/laser_host.sv
// rtl/laser_host.sv - image store and sequencer driving the LASER solver
// LASER_HOST_SCORE_EN adds the SCORE state and coverage count.
module laser_host
  import laser_pkg::*;
#(
  parameter int IMG_NUM = 4,
  parameter int TIMEOUT = 1023,
  localparam int IW = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1,
  localparam int AW = $clog2(IMG_NUM * PT_NUM)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               start,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               DONE,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  output logic               res_valid,
  output logic [IW-1:0]      res_img,
  output logic [COORD_W-1:0] res_c1x,
  output logic [COORD_W-1:0] res_c1y,
  output logic [COORD_W-1:0] res_c2x,
  output logic [COORD_W-1:0] res_c2y,
  output logic [COVER_W-1:0] res_cover,
  output logic               res_timeout,
  output logic               busy,
  output logic               all_done
);
  localparam int DEPTH = IMG_NUM * PT_NUM;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [5:0] PT_LAST = 6'(PT_NUM - 1);
  localparam logic [IW-1:0] IMG_LAST = IW'(IMG_NUM - 1);

  logic [2*COORD_W-1:0] mem_q [DEPTH];

  state_t               state_q, state_d;
  logic [IW-1:0]        img_q, img_d, res_img_q, res_img_d;
  logic [5:0]           pt_q, pt_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]   c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic                 timeout_q, timeout_d;
  logic [AW-1:0]        send_addr;
  logic [2*COORD_W-1:0] send_pt;

  always_ff @(posedge CLK) begin
    if (wr_en && 32'(wr_addr) < DEPTH) mem_q[wr_addr] <= {wr_x, wr_y};
  end

`ifdef LASER_HOST_SCORE_EN
  logic [COVER_W-1:0]   cover_q, cover_d;
  logic [AW-1:0]        score_addr;
  logic [2*COORD_W-1:0] score_pt;
  logic                 covered;

  assign score_addr = AW'(img_q) * AW'(PT_NUM) + AW'(pt_q);
  assign score_pt   = mem_q[score_addr];

  laser_cover_chk u_cover_chk (
    .px(score_pt[2*COORD_W-1:COORD_W]), .py(score_pt[COORD_W-1:0]),
    .c1x(c1x_q), .c1y(c1y_q), .c2x(c2x_q), .c2y(c2y_q),
    .covered(covered)
  );
`endif

  always_comb begin
    state_d   = state_q;
    img_d     = img_q;
    pt_d      = pt_q;
    wait_d    = wait_q;
    c1x_d     = c1x_q;
    c1y_d     = c1y_q;
    c2x_d     = c2x_q;
    c2y_d     = c2y_q;
    timeout_d = timeout_q;
    res_img_d = res_img_q;
`ifdef LASER_HOST_SCORE_EN
    cover_d   = cover_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_SEND;
        img_d     = '0;
        pt_d      = '0;
        timeout_d = 1'b0;
      end
      S_SEND: if (pt_q == PT_LAST) begin
        state_d = S_WAIT;
        pt_d    = '0;
        wait_d  = '0;
      end else begin
        pt_d = pt_q + 6'd1;
      end
      S_WAIT: if (DONE) begin
        c1x_d = C1X;
        c1y_d = C1Y;
        c2x_d = C2X;
        c2y_d = C2Y;
`ifdef LASER_HOST_SCORE_EN
        cover_d = '0;
        state_d = S_SCORE;
`else
        state_d = S_REPORT;
`endif
      end else if (wait_q == WW'(TIMEOUT - 1)) begin
        state_d   = S_REPORT;
        timeout_d = 1'b1;
        c1x_d     = '0;
        c1y_d     = '0;
        c2x_d     = '0;
        c2y_d     = '0;
`ifdef LASER_HOST_SCORE_EN
        cover_d   = '0;
`endif
      end else begin
        wait_d = wait_q + WW'(1);
      end
`ifdef LASER_HOST_SCORE_EN
      S_SCORE: begin
        cover_d = cover_q + COVER_W'(covered);
        if (pt_q == PT_LAST) begin
          state_d = S_REPORT;
          pt_d    = '0;
        end else begin
          pt_d = pt_q + 6'd1;
        end
      end
`endif
      // Chaining straight into the next SEND keeps the solver stream gap-free.
      S_REPORT: if (img_q == IMG_LAST) begin
        state_d = S_IDLE;
      end else begin
        state_d   = S_SEND;
        img_d     = img_q + IW'(1);
        pt_d      = '0;
        timeout_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_REPORT) res_img_d = img_q;
  end

  // X/Y are registered, so fetch the point that will be on the bus next cycle.
  assign send_addr = AW'(img_d) * AW'(PT_NUM) + AW'(pt_d);
  assign send_pt   = mem_q[send_addr];

  always_comb begin
    x_d = '0;
    y_d = '0;
    if (state_d == S_SEND) {x_d, y_d} = send_pt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      img_q     <= '0;
      pt_q      <= '0;
      wait_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      c1x_q     <= '0;
      c1y_q     <= '0;
      c2x_q     <= '0;
      c2y_q     <= '0;
      timeout_q <= 1'b0;
      res_img_q <= '0;
`ifdef LASER_HOST_SCORE_EN
      cover_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      img_q     <= img_d;
      pt_q      <= pt_d;
      wait_q    <= wait_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c1x_q     <= c1x_d;
      c1y_q     <= c1y_d;
      c2x_q     <= c2x_d;
      c2y_q     <= c2y_d;
      timeout_q <= timeout_d;
      res_img_q <= res_img_d;
`ifdef LASER_HOST_SCORE_EN
      cover_q   <= cover_d;
`endif
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign res_valid   = (state_q == S_REPORT);
  assign all_done    = res_valid && (img_q == IMG_LAST);
  assign busy        = (state_q != S_IDLE);
  assign res_img     = res_img_q;
  assign res_c1x     = c1x_q;
  assign res_c1y     = c1y_q;
  assign res_c2x     = c2x_q;
  assign res_c2y     = c2y_q;
  assign res_timeout = timeout_q;
`ifdef LASER_HOST_SCORE_EN
  assign res_cover   = cover_q;
`else
  assign res_cover   = '0;
`endif
endmodule

// File: tb/tb_laser_host.sv
// tb/tb_laser_host.sv - directed self-checking bench for laser_host
// Cover and latency expectations follow LASER_HOST_SCORE_EN.
module tb_laser_host;
  import laser_pkg::*;

  localparam int IMG = 4;
  localparam int TMO = 50;
`ifdef LASER_HOST_SCORE_EN
  localparam int SCORE_LAT = 40;
  localparam bit SCORE_ON  = 1'b1;
`else
  localparam int SCORE_LAT = 0;
  localparam bit SCORE_ON  = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [3:0] wr_x = '0, wr_y = '0;
  logic       start = 1'b0;
  logic       DONE = 1'b1;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic [3:0] X, Y, res_c1x, res_c1y, res_c2x, res_c2y;
  logic [1:0] res_img;
  logic [5:0] res_cover;
  logic       res_valid, res_timeout, busy, all_done;

  logic [3:0] px = '0, py = '0, c1x = '0, c1y = '0, c2x = '0, c2y = '0;
  logic       covered;

  logic [3:0] mx [IMG*PT_NUM];
  logic [3:0] my [IMG*PT_NUM];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  laser_host #(.IMG_NUM(IMG), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .X(X), .Y(Y), .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .res_valid(res_valid), .res_img(res_img), .res_c1x(res_c1x), .res_c1y(res_c1y),
    .res_c2x(res_c2x), .res_c2y(res_c2y), .res_cover(res_cover), .res_timeout(res_timeout),
    .busy(busy), .all_done(all_done)
  );

  laser_cover_chk u_chk (
    .px(px), .py(py), .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y), .covered(covered)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cov(input int v);
    return SCORE_ON ? v : 0;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic write_img(input int img);
    for (int i = 0; i < PT_NUM; i++) begin
      wr_en = 1'b1; wr_addr = 8'(img*PT_NUM + i);
      wr_x = mx[img*PT_NUM + i]; wr_y = my[img*PT_NUM + i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Checks all 40 points of a stream; a stray start mid-stream must be ignored.
  task automatic stream(input int img, input string tag);
    for (int i = 0; i < PT_NUM; i++) begin
      chk($sformatf("%s_x%0d", tag, i), X, mx[img*PT_NUM + i]);
      chk($sformatf("%s_y%0d", tag, i), Y, my[img*PT_NUM + i]);
      if (i == 3) DONE = 1'b0;
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    chk({tag, "_wait_x"}, X, 0);
    chk({tag, "_wait_busy"}, busy, 1);
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int k = 0;
    while (res_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, exp_lat);
  endtask

  task automatic give_done(input logic [3:0] ax, ay, bx, by);
    DONE = 1'b1; C1X = ax; C1Y = ay; C2X = bx; C2Y = by;
    tick();
    DONE = 1'b0; C1X = 4'd9; C1Y = 4'd9; C2X = 4'd9; C2Y = 4'd9;
  endtask

  initial begin
    for (int i = 0; i < PT_NUM; i++) begin
      mx[i] = 4'd3; my[i] = 4'd3;
      mx[PT_NUM + i] = 4'(i % 16); my[PT_NUM + i] = 4'(15 - i % 16);
      mx[2*PT_NUM + i] = (i < 16) ? 4'd0 : 4'd15;
      my[2*PT_NUM + i] = (i < 16) ? 4'(i) : 4'((i - 16) % 16);
      mx[3*PT_NUM + i] = 4'd7; my[3*PT_NUM + i] = 4'd7;
    end

    // Cover checker boundaries: d2 = 16 in, 25 out, abs-difference and 9-bit sum.
    px = 0; py = 8; c1x = 0; c1y = 4; c2x = 15; c2y = 4; #1;
    chk("chk_d2_16", covered, 1);
    py = 9; #1;
    chk("chk_d2_25", covered, 0);
    px = 15; py = 8; #1;
    chk("chk_c2_only", covered, 1);
    px = 0; py = 0; c2x = 15; c2y = 15; #1;
    chk("chk_abs_neg", covered, 1);
    px = 15; py = 6; c1x = 0; c1y = 0; c2x = 0; c2y = 0; #1;
    chk("chk_d2_261", covered, 0);

    repeat (3) tick();
    chk("rst_x", X, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_cover", res_cover, 0);
    chk("rst_timeout", res_timeout, 0);
    RST = 1'b0;
    for (int img = 0; img < IMG; img++) write_img(img);
    chk("idle_x", X, 0);
    chk("idle_busy", busy, 0);

    start = 1'b1; tick(); start = 1'b0;
    chk("i0_busy", busy, 1);
    stream(0, "i0");
    give_done(4'd3, 4'd3, 4'd12, 4'd12);
    wait_result("i0", SCORE_LAT);
    chk("i0_img", res_img, 0);
    chk("i0_c1x", res_c1x, 3);
    chk("i0_c1y", res_c1y, 3);
    chk("i0_c2x", res_c2x, 12);
    chk("i0_cover", res_cover, exp_cov(40));
    chk("i0_all_done", all_done, 0);
    tick();
    chk("i0_valid_pulse", res_valid, 0);

    stream(1, "i1");
    chk("i1_hold_c1x", res_c1x, 3);
    wait_result("i1", TMO);
    chk("i1_timeout", res_timeout, 1);
    chk("i1_c1x", res_c1x, 0);
    chk("i1_c2y", res_c2y, 0);
    chk("i1_cover", res_cover, 0);
    chk("i1_img", res_img, 1);
    chk("i1_all_done", all_done, 0);
    tick();
    chk("i2_timeout_clr", res_timeout, 0);
    chk("i2_valid_pulse", res_valid, 0);

    // Columns x=0 and x=15: y 0..8 covered -> 9 + 9 (y 0..15) + 8 (y 0..7) = 26.
    stream(2, "i2");
    repeat (2) tick();
    give_done(4'd0, 4'd4, 4'd15, 4'd4);
    wait_result("i2", SCORE_LAT);
    chk("i2_cover", res_cover, exp_cov(26));
    chk("i2_img", res_img, 2);
    chk("i2_c1y", res_c1y, 4);
    chk("i2_c2x", res_c2x, 15);
    chk("i2_all_done", all_done, 0);
    tick();

    stream(3, "i3");
    give_done(4'd7, 4'd7, 4'd7, 4'd7);
    wait_result("i3", SCORE_LAT);
    chk("i3_cover", res_cover, exp_cov(40));
    chk("i3_img", res_img, 3);
    chk("i3_all_done", all_done, 1);
    tick();
    chk("end_busy", busy, 0);
    chk("end_all_done", all_done, 0);
    chk("end_valid", res_valid, 0);
    chk("end_hold_cover", res_cover, exp_cov(40));
    chk("end_hold_img", res_img, 3);

    // Distinct points so a restart from point 0 is observable.
    for (int i = 0; i < PT_NUM; i++) begin
      mx[i] = 4'(i % 16); my[i] = 4'((i * 7) % 16);
    end
    write_img(0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    chk("rs_pt20_x", X, mx[20]);
    chk("rs_pt20_y", Y, my[20]);
    RST = 1'b1; #1;
    chk("rs_x", X, 0);
    chk("rs_y", Y, 0);
    chk("rs_busy", busy, 0);
    chk("rs_c1x", res_c1x, 0);
    chk("rs_img", res_img, 0);
    repeat (2) tick();
    chk("rs_all_done", all_done, 0);
    chk("rs_valid", res_valid, 0);
    RST = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    stream(0, "rs");
    give_done(4'd1, 4'd1, 4'd2, 4'd2);
    wait_result("rs", SCORE_LAT);
    chk("rs_res_img", res_img, 0);
    chk("rs_res_c2x", res_c2x, 2);
    chk("rs_res_all_done", all_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
